uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 146 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start bit, LSB-first data, optional parity, stop bits
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_clk,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  // Counter must reach DATA_BITS-1 without wrapping; it also counts stop intervals.
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           r_state;
  logic                 r_baud_q;
  logic                 r_live;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_tick;

  // r_live masks the first cycle after reset release so a baud_clk already
  // high at release cannot be mistaken for a rising edge.
  assign w_bit_tick = baud_clk & ~r_baud_q & r_live;

  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

  // Baud edge detector: delayed copy of baud_clk plus post-reset qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_q <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_baud_q <= baud_clk;
      r_live   <= 1'b1;
    end
  end

  // Frame sequencer: every line change happens on the edge that consumes a tick,
  // so tx only moves in the cycle after bit_tick and always comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (tx_start) begin
            r_shift  <= data_in;
            r_cnt    <= '0;
            r_parity <= (^data_in) ^ PAR_ODD;
            r_busy   <= 1'b1;
            r_state  <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_bit_tick) begin
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_cnt   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            if (r_cnt == LAST_DATA) begin
              r_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_cnt   <= r_cnt + CNT_ONE;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_tick) begin
            r_tx    <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_tick) begin
            if (r_cnt == LAST_STOP) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer
`timescale 1ns/1ps
module tb_uart_tx_framer;

  typedef struct {
    int          len;
    logic [15:0] bits;      // bit 0 is the first bit on the line
    int          abort_at;  // frame index where reset is expected, -1 for none
  } frame_t;

  // Hand-built line sequences (listed first-to-last on the line).
  // A5 : 0 1010 0101 1 -> 0,1,0,1,0,0,1,0,1,1
  localparam logic [15:0] FR_A5 = 16'b0000_0011_0100_1010;
  // 55 : 0,1,0,1,0,1,0,1,0,1
  localparam logic [15:0] FR_55 = 16'b0000_0010_1010_1010;
  // C3 : 0,1,1,0,0,0,0,1,1,1
  localparam logic [15:0] FR_C3 = 16'b0000_0011_1000_0110;
  // 81 : 0,1,0,0,0,0,0,0,1,1
  localparam logic [15:0] FR_81 = 16'b0000_0011_0000_0010;
  // 07 even parity, two stops : 0,1,1,1,0,0,0,0,0,1,1,1
  localparam logic [15:0] FR_07E = 16'b0000_1110_0000_1110;
  // 07 odd parity, one stop : 0,1,1,1,0,0,0,0,0,0,1
  localparam logic [15:0] FR_07O = 16'b0000_0100_0000_1110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_clk = 1'b0;
  logic [2:0] tx_start_v = 3'b000;
  logic [7:0] d0 = 8'h00;
  logic [7:0] d1 = 8'h00;
  logic [7:0] d2 = 8'h00;
  wire  [2:0] tx_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;

  int checks = 0;
  int errors = 0;
  int done_seen[3] = '{0, 0, 0};
  int exp_done[3]  = '{0, 0, 0};
  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  uart_tx_framer dut0 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_start(tx_start_v[0]),
    .data_in(d0), .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0])
  );

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_start(tx_start_v[1]),
    .data_in(d1), .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1])
  );

  uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_start(tx_start_v[2]),
    .data_in(d2), .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2])
  );

  always #5 clk = ~clk;

  // baud_clk toggles every 4 clk, just after the rising edge
  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 baud_clk = ~baud_clk;
    end
  end

  always @(negedge clk) begin
    if (done_v[0]) done_seen[0] <= done_seen[0] + 1;
    if (done_v[1]) done_seen[1] <= done_seen[1] + 1;
    if (done_v[2]) done_seen[2] <= done_seen[2] + 1;
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int len, input logic [15:0] bits, input int abort_at);
    frame_t f;
    f.len = len;
    f.bits = bits;
    f.abort_at = abort_at;
    case (k)
      0: q0.push_back(f);
      1: q1.push_back(f);
      default: q2.push_back(f);
    endcase
    if (abort_at < 0) exp_done[k]++;
  endtask

  // Waits for a start bit, then checks each bit over its full 8-clk interval
  // and the tx_done / tx_busy handshake in the cycle after the last stop bit.
  task automatic monitor(input int k);
    frame_t f;
    logic   prev;
    bit     have;
    bit     ok;
    bit     aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev === 1'b1 && tx_v[k] === 1'b0) begin
        have = 1'b1;
        case (k)
          0: if (q0.size() > 0) f = q0.pop_front(); else have = 1'b0;
          1: if (q1.size() > 0) f = q1.pop_front(); else have = 1'b0;
          default: if (q2.size() > 0) f = q2.pop_front(); else have = 1'b0;
        endcase
        check(have, $sformatf("dut%0d frame expected", k), int'(have), 1);
        if (have) begin
          aborted = 1'b0;
          for (int i = 0; i < f.len && !aborted; i++) begin
            ok = 1'b1;
            for (int c = 0; c < 8; c++) begin
              if (i != 0 || c != 0) @(negedge clk);
              if (!rst_n) begin
                aborted = 1'b1;
                break;
              end
              if (tx_v[k] !== f.bits[i] || busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) ok = 1'b0;
            end
            if (aborted)
              check(i == f.abort_at, $sformatf("dut%0d abort point", k), i, f.abort_at);
            else
              check(ok, $sformatf("dut%0d bit%0d", k, i), int'(tx_v[k]), int'(f.bits[i]));
          end
          if (!aborted) begin
            check(f.abort_at < 0, $sformatf("dut%0d frame completed", k), f.abort_at, -1);
            @(negedge clk);
            check(done_v[k] === 1'b1 && busy_v[k] === 1'b0 && tx_v[k] === 1'b1,
                  $sformatf("dut%0d frame end done/busy/tx", k),
                  int'({done_v[k], busy_v[k], tx_v[k]}), 5);
          end
        end
      end
      prev = tx_v[k];
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic send(input int k, input logic [7:0] d);
    case (k)
      0: d0 = d;
      1: d1 = d;
      default: d2 = d;
    endcase
    tx_start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    tx_start_v[k] = 1'b0;
    check(busy_v[k] === 1'b1, $sformatf("dut%0d busy after accept", k), int'(busy_v[k]), 1);
  endtask

  task automatic wait_fall(input int k, output int n);
    n = 0;
    while (tx_v[k] !== 1'b0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (busy_v[k] !== 1'b0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n < 400, $sformatf("dut%0d returns idle", k), n, 400);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (done_v[k] !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n < 400, $sformatf("dut%0d tx_done seen", k), n, 400);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check(tx_v === 3'b111, "reset tx", int'(tx_v), 7);
    check(busy_v === 3'b000, "reset busy", int'(busy_v), 0);
    check(done_v === 3'b000, "reset done", int'(done_v), 0);

    // release while baud_clk is high; idle must ignore it
    @(posedge baud_clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check(tx_v === 3'b111 && busy_v === 3'b000, "idle after release", int'({tx_v, busy_v}), 56);

    // default A5 frame alongside parity-even/2-stop and parity-odd 0x07 frames
    push(0, 10, FR_A5, -1);
    push(1, 12, FR_07E, -1);
    push(2, 11, FR_07O, -1);
    d0 = 8'hA5;
    d1 = 8'h07;
    d2 = 8'h07;
    tx_start_v = 3'b111;
    @(posedge clk);
    #1;
    tx_start_v = 3'b000;
    check(busy_v === 3'b111, "busy after multi accept", int'(busy_v), 7);
    wait_fall(0, n);
    check(n >= 1 && n <= 8, "first start bit within one tick", n, 8);
    wait_idle(0);
    wait_idle(2);
    wait_idle(1);

    // second tx_start mid-frame is ignored
    push(0, 10, FR_A5, -1);
    send(0, 8'hA5);
    repeat (20) @(posedge clk);
    #1;
    d0 = 8'h3C;
    tx_start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_start_v[0] = 1'b0;
    check(busy_v[0] === 1'b1, "busy during rejected start", int'(busy_v[0]), 1);

    // back-to-back 0x55 requested in the tx_done cycle
    push(0, 10, FR_55, -1);
    wait_done(0);
    check(busy_v[0] === 1'b0, "busy low in done cycle", int'(busy_v[0]), 0);
    d0 = 8'h55;
    tx_start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_start_v[0] = 1'b0;
    check(busy_v[0] === 1'b1 && done_v[0] === 1'b0, "b2b busy back after one cycle",
          int'({busy_v[0], done_v[0]}), 2);
    wait_fall(0, n);
    check(n == 7, "b2b start bit at next tick", n, 7);
    wait_idle(0);

    // tx_start coincident with bit_tick: that tick must not start the frame
    push(0, 10, FR_C3, -1);
    @(posedge baud_clk);
    d0 = 8'hC3;
    tx_start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    tx_start_v[0] = 1'b0;
    check(busy_v[0] === 1'b1, "busy after coincident accept", int'(busy_v[0]), 1);
    wait_fall(0, n);
    check(n == 8, "coincident tick skipped", n, 8);
    wait_idle(0);

    // reset during data bit 3 (frame index 4)
    push(0, 10, FR_A5, 4);
    send(0, 8'hA5);
    wait_fall(0, n);
    repeat (35) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check(tx_v[0] === 1'b1, "async reset tx high", int'(tx_v[0]), 1);
    check(busy_v[0] === 1'b0, "async reset busy low", int'(busy_v[0]), 0);
    check(done_v[0] === 1'b0, "async reset no done", int'(done_v[0]), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    check(tx_v[0] === 1'b1 && busy_v[0] === 1'b0, "no resumption after reset",
          int'({tx_v[0], busy_v[0]}), 2);

    // fresh frame after reset
    push(0, 10, FR_81, -1);
    send(0, 8'h81);
    wait_idle(0);
    repeat (4) @(posedge clk);
    #1;

    check(q0.size() == 0 && q1.size() == 0 && q2.size() == 0, "scoreboard drained",
          q0.size() + q1.size() + q2.size(), 0);
    for (int k = 0; k < 3; k++)
      check(done_seen[k] == exp_done[k], $sformatf("dut%0d tx_done count", k), done_seen[k], exp_done[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
